// File: rtl/cache_tb_pkg.sv
// cache_tb_pkg: shared op/state encodings and the expected-read entry type
// for cache_req_gen and its expected-read FIFO.
package cache_tb_pkg;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10} op_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT} state_e;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_entry_t;
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/cache_req_gen_if.sv
// cache_req_gen_if: command stream plus L1 cache request/response bus.
// master: the request generator (accepts commands, drives a/be/read/write/wd).
// slave:  the command source and cache model on the other side.
interface cache_req_gen_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_data;
    logic [31:0] a;
    logic [3:0]  be;
    logic        read;
    logic        write;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] rd;
    logic        rd_valid;
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_be, cmd_data, ready, rd, rd_valid,
        output cmd_ready, a, be, read, write, wd
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_be, cmd_data, ready, rd, rd_valid,
        input  cmd_ready, a, be, read, write, wd
    );
endinterface

// File: rtl/exp_fifo.sv
// exp_fifo: synchronous FIFO of expected read entries.
// Ports: clk, reset (sync active-low), i_push/i_din, i_pop, o_dout (head),
// o_full, o_empty, o_count. Push when full and pop when empty are ignored.
import cache_tb_pkg::*;
module exp_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = exp_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  T                       i_din,
    input  logic                   i_pop,
    output T                       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [AW:0]    r_cnt;
    logic           w_push, w_pop;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rp];
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/cache_req_gen.sv
// cache_req_gen: CPU-side L1 request initiator with in-order read checking.
// Ports: clk, reset (sync active-low), bus (command + cache bus, master view),
// busy, rd_count/wr_count/err_count (saturating), err_pulse, last_err_addr,
// timeout (sticky until reset).
import cache_tb_pkg::*;
module cache_req_gen #(
    parameter int OUTSTANDING = 4,
    parameter int MAX_WAIT    = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    cache_req_gen_if.master     bus,
    output logic                busy,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count,
    output logic [CNT_W-1:0]    err_count,
    output logic                err_pulse,
    output logic [31:0]         last_err_addr,
    output logic                timeout
);
    localparam int CW = $clog2(OUTSTANDING) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    state_e            r_state, w_next;
    logic              r_cmd_ready, r_is_rd, r_err_pulse;
    logic [31:0]       r_a, r_wd, r_last_err;
    logic [3:0]        r_be;
    logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt, r_err_cnt;
    logic [WW-1:0]     r_wdog;
    logic              w_full, w_empty, w_start, w_acc, w_clr, w_stall, w_to, w_mis, w_err;
    logic [CW-1:0]     w_count;
    exp_entry_t        w_head;

    exp_fifo #(.DEPTH(OUTSTANDING), .T(exp_entry_t)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_acc & r_is_rd),
        .i_din   ('{addr: r_a, be: r_be, data: r_wd}),
        .i_pop   (bus.rd_valid),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // cmd_ready is only ever high in IDLE, so a handshake implies IDLE.
    assign w_start   = bus.cmd_valid & r_cmd_ready & (bus.cmd_op == OP_RD || bus.cmd_op == OP_WR);
    // read gating uses the registered FIFO count only
    assign bus.read  = (r_state == S_REQ) & r_is_rd & ~w_full;
    assign bus.write = (r_state == S_REQ) & ~r_is_rd;
    assign w_acc     = (bus.read | bus.write) & bus.ready;
    assign w_clr     = w_acc | bus.rd_valid;
    // with no acceptance and no response, any pending request or queued read is a stall
    assign w_stall   = (r_state == S_REQ) | ~w_empty;
    assign w_to      = (r_state != S_HALT) & ~w_clr & w_stall & (r_wdog == WW'(MAX_WAIT - 1));
    assign w_mis     = |((w_head.data ^ bus.rd) & be_mask(w_head.be));
    assign w_err     = bus.rd_valid & (w_empty | w_mis);

    always_comb begin
        w_next = r_state;
        if (w_to)
            w_next = S_HALT;
        else if (r_state == S_IDLE && w_start)
            w_next = S_REQ;
        else if (r_state == S_REQ && w_acc)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_is_rd     <= 1'b0;
            r_a         <= '0;
            r_be        <= '0;
            r_wd        <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_last_err  <= '0;
            r_wdog      <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= w_next == S_IDLE;
            if (w_start) begin
                r_is_rd <= bus.cmd_op == OP_RD;
                r_a     <= bus.cmd_addr;
                r_be    <= bus.cmd_be;
                r_wd    <= bus.cmd_data;
            end
            r_rd_cnt    <= r_rd_cnt + CNT_W'(w_acc & r_is_rd & ~&r_rd_cnt);
            r_wr_cnt    <= r_wr_cnt + CNT_W'(w_acc & ~r_is_rd & ~&r_wr_cnt);
            r_err_cnt   <= r_err_cnt + CNT_W'(w_err & ~&r_err_cnt);
            r_err_pulse <= w_err;
            if (bus.rd_valid && !w_empty && w_mis) r_last_err <= w_head.addr;
            // frozen at 0 in HALT so it cannot wrap while responses trickle in
            r_wdog      <= (w_clr || r_state == S_HALT || !w_stall) ? '0 : r_wdog + WW'(1);
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.a         = r_a;
    assign bus.be        = r_be;
    assign bus.wd        = r_wd;
    assign busy          = (r_state == S_REQ) | (w_count != '0);
    assign rd_count      = r_rd_cnt;
    assign wr_count      = r_wr_cnt;
    assign err_count     = r_err_cnt;
    assign err_pulse     = r_err_pulse;
    assign last_err_addr = r_last_err;
    assign timeout       = r_state == S_HALT;
endmodule

// File: tb/tb_cache_req_gen.sv
// tb_cache_req_gen: directed and randomized bench for cache_req_gen against a
// queue-based reference model of accepted reads, counters and errors.
module tb_cache_req_gen;
    import cache_tb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy, err_pulse, timeout;
    logic [15:0] rd_count, wr_count, err_count;
    logic [31:0] last_err_addr;
    int          checks = 0;
    int          failures = 0;

    int          m_rd, m_wr, m_err;
    logic [31:0] m_last;
    logic        m_pulse;
    exp_entry_t  m_q[$];

    always #5 clk = ~clk;

    cache_req_gen_if bus();

    cache_req_gen #(.OUTSTANDING(4), .MAX_WAIT(64), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .rd_count      (rd_count),
        .wr_count      (wr_count),
        .err_count     (err_count),
        .err_pulse     (err_pulse),
        .last_err_addr (last_err_addr),
        .timeout       (timeout)
    );

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish within 1ms");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_rd = 0; m_wr = 0; m_err = 0; m_last = '0; m_pulse = 1'b0;
        m_q.delete();
    endtask

    function automatic bit model_mismatch(input exp_entry_t e, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (e.be[i] && e.data[8*i +: 8] != d[8*i +: 8]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        bus.cmd_valid = 1'b0; bus.rd_valid = 1'b0; bus.ready = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        model_clear();
    endtask

    // Presents a command and returns in the cycle after its handshake.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] data);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr;
        bus.cmd_be = be; bus.cmd_data = data;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_wait: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Read or write held for k cycles with ready low, then accepted.
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data, input int k);
        send_cmd(op, addr, be, data);
        bus.ready = 1'b0;
        repeat (k) tick();
        bus.ready = 1'b1;
        tick();
        if (op == OP_RD) begin
            m_q.push_back('{addr: addr, be: be, data: data});
            m_rd++;
        end else m_wr++;
    endtask

    // One-cycle response; returns in the cycle after rd_valid.
    task automatic respond(input logic [31:0] d);
        exp_entry_t e;
        bus.rd_valid = 1'b1; bus.rd = d;
        tick();
        bus.rd_valid = 1'b0;
        m_pulse = 1'b0;
        if (m_q.size() == 0) begin
            m_err++;
            m_pulse = 1'b1;
        end else begin
            e = m_q.pop_front();
            if (model_mismatch(e, d)) begin
                m_err++;
                m_last = e.addr;
                m_pulse = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.a, bus.be, bus.wd, bus.read, bus.write, bus.cmd_ready, busy, rd_count, wr_count,
             err_count, err_pulse, last_err_addr, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: cmd_ready=%b busy=%b read=%b write=%b a=%h cnts=%0d/%0d/%0d, required all 0",
                     bus.cmd_ready, busy, bus.read, bus.write, bus.a, rd_count, wr_count, err_count);
        end
        reset = 1'b1;
        tick();
        model_clear();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_read();
        bus.ready = 1'b1;
        send_cmd(OP_WR, 32'h100, 4'hF, 32'hDEADBEEF);
        checks++;
        if ({bus.write, bus.read, bus.a, bus.wd} !== {2'b10, 32'h100, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL wr_issue: write=%b read=%b a=%h wd=%h, required 1 0 100 deadbeef",
                     bus.write, bus.read, bus.a, bus.wd);
        end
        tick();
        m_wr++;
        checks++;
        if ({bus.write, bus.cmd_ready, wr_count} !== {1'b0, 1'b1, 16'(m_wr)}) begin
            failures++;
            $display("FAIL wr_accept: write=%b cmd_ready=%b wr_count=%0d, required 0 1 %0d",
                     bus.write, bus.cmd_ready, wr_count, m_wr);
        end
        do_req(OP_RD, 32'h100, 4'hF, 32'hDEADBEEF, 0);
        respond(32'hDEADBEEF);
        checks++;
        if ({err_count, rd_count, err_pulse} !== {16'(m_err), 16'(m_rd), m_pulse}) begin
            failures++;
            $display("FAIL rd_match: err_count=%0d rd_count=%0d err_pulse=%b, required %0d %0d %b",
                     err_count, rd_count, err_pulse, m_err, m_rd, m_pulse);
        end
    endtask

    task automatic test_masked();
        do_req(OP_RD, 32'h40, 4'h3, 32'h0000_1234, 1);
        respond(32'hFFFF_1234);
        checks++;
        if (err_count !== 16'(m_err) || m_err != 0) begin
            failures++;
            $display("FAIL masked_ok: err_count=%0d, required %0d (model) and 0", err_count, m_err);
        end
        do_req(OP_RD, 32'h40, 4'h3, 32'h0000_1234, 0);
        respond(32'h0000_1235);
        checks++;
        if ({err_count, last_err_addr, err_pulse} !== {16'(m_err), m_last, m_pulse} || m_err != 1) begin
            failures++;
            $display("FAIL masked_err: err_count=%0d last=%h pulse=%b, required %0d %h %b",
                     err_count, last_err_addr, err_pulse, m_err, m_last, m_pulse);
        end
        tick();
        checks++;
        if (err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL masked_pulse_len: err_pulse=%b one cycle later, required 0", err_pulse);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) do_req(OP_RD, 32'h200 + 32'(4*i), 4'hF, $urandom, 0);
        send_cmd(OP_RD, 32'h300, 4'hF, 32'h5555_AAAA);
        repeat (3) tick();
        checks++;
        if ({bus.read, bus.cmd_ready, busy, rd_count} !== {1'b0, 1'b0, 1'b1, 16'd4}) begin
            failures++;
            $display("FAIL full_gate: read=%b cmd_ready=%b busy=%b rd_count=%0d, required 0 0 1 4",
                     bus.read, bus.cmd_ready, busy, rd_count);
        end
        respond(m_q[0].data);
        checks++;
        if (bus.read !== 1'b1) begin
            failures++;
            $display("FAIL full_release: read=%b one cycle after rd_valid, required 1", bus.read);
        end
        tick();
        m_q.push_back('{addr: 32'h300, be: 4'hF, data: 32'h5555_AAAA});
        m_rd++;
        send_cmd(OP_RD, 32'h304, 4'hF, 32'h0F0F_0F0F);
        checks++;
        if ({bus.read, rd_count} !== {1'b0, 16'(m_rd)}) begin
            failures++;
            $display("FAIL full_sixth: read=%b rd_count=%0d, required 0 %0d", bus.read, rd_count, m_rd);
        end
        respond(m_q[0].data);
        tick();
        m_q.push_back('{addr: 32'h304, be: 4'hF, data: 32'h0F0F_0F0F});
        m_rd++;
        while (m_q.size() > 0) respond(m_q[0].data);
        checks++;
        if ({rd_count, err_count, busy} !== {16'(m_rd), 16'(m_err), 1'b0} || m_rd != 6) begin
            failures++;
            $display("FAIL full_drain: rd_count=%0d err_count=%0d busy=%b, required %0d %0d 0",
                     rd_count, err_count, busy, m_rd, m_err);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        respond($urandom);
        checks++;
        if ({err_count, err_pulse, last_err_addr} !== {16'd1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL spurious: err_count=%0d pulse=%b last=%h, required 1 1 0",
                     err_count, err_pulse, last_err_addr);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.ready = 1'b1;
        do_req(OP_RD, 32'h500, 4'hF, $urandom, 0);
        do_req(OP_RD, 32'h504, 4'hF, $urandom, 0);
        checks++;
        if ({busy, rd_count} !== {1'b1, 16'd2}) begin
            failures++;
            $display("FAIL midflight_pre: busy=%b rd_count=%0d, required 1 2", busy, rd_count);
        end
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.a, bus.be, bus.wd, bus.read, bus.write, bus.cmd_ready, busy, rd_count, wr_count,
             err_count, err_pulse, last_err_addr, timeout} !== '0) begin
            failures++;
            $display("FAIL midflight_reset: busy=%b cmd_ready=%b rd_count=%0d a=%h, required all 0",
                     busy, bus.cmd_ready, rd_count, bus.a);
        end
        reset = 1'b1;
        tick();
        model_clear();
        respond($urandom);
        checks++;
        if ({err_count, err_pulse, last_err_addr, busy} !== {16'(m_err), m_pulse, m_last, 1'b0} || m_err != 1) begin
            failures++;
            $display("FAIL midflight_spurious: err_count=%0d pulse=%b last=%h busy=%b, required %0d %b %h 0",
                     err_count, err_pulse, last_err_addr, busy, m_err, m_pulse, m_last);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] addr, data, rdv, noise;
        logic [3:0]  be;
        int          mode;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            op = 2'($urandom_range(0, 3)); addr = $urandom; be = 4'($urandom_range(0, 15)); data = $urandom;
            if (op == OP_RD || op == OP_WR) begin
                do_req(op, addr, be, data, $urandom_range(0, 3));
                checks++;
                if ({bus.read, bus.write, bus.cmd_ready} !== 3'b001) begin
                    failures++;
                    $display("FAIL rand_accept it=%0d: read=%b write=%b cmd_ready=%b, required 0 0 1",
                             it, bus.read, bus.write, bus.cmd_ready);
                end
                if (op == OP_RD) begin
                    mode = $urandom_range(0, 2);
                    noise = $urandom;
                    for (int i = 0; i < 4; i++) if (be[i]) noise[8*i +: 8] = 8'h00;
                    rdv = mode == 0 ? data : mode == 1 ? data ^ noise : data ^ (32'd1 << $urandom_range(0, 31));
                    respond(rdv);
                end
            end else begin
                send_cmd(op, addr, be, data);
                checks++;
                if ({bus.read, bus.write, bus.cmd_ready} !== 3'b001) begin
                    failures++;
                    $display("FAIL rand_nop it=%0d: read=%b write=%b cmd_ready=%b, required 0 0 1",
                             it, bus.read, bus.write, bus.cmd_ready);
                end
            end
            checks++;
            if ({rd_count, wr_count, err_count, last_err_addr, busy} !==
                {16'(m_rd), 16'(m_wr), 16'(m_err), m_last, 1'b0}) begin
                failures++;
                $display("FAIL rand_state it=%0d: rd=%0d wr=%0d err=%0d last=%h busy=%b, required %0d %0d %0d %h 0",
                         it, rd_count, wr_count, err_count, last_err_addr, busy, m_rd, m_wr, m_err, m_last);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        send_cmd(OP_WR, 32'h700, 4'hF, 32'h1234_5678);
        while (bus.write === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != 64 || {timeout, bus.write, bus.cmd_ready} !== 3'b100) begin
            failures++;
            $display("FAIL timeout_fire: write high %0d cycles timeout=%b write=%b cmd_ready=%b, required 64 1 0 0",
                     n, timeout, bus.write, bus.cmd_ready);
        end
        bus.ready = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = OP_RD;
        repeat (5) tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({timeout, bus.write, bus.read, bus.cmd_ready, wr_count} !== {4'b1000, 16'd0}) begin
            failures++;
            $display("FAIL timeout_sticky: timeout=%b write=%b read=%b cmd_ready=%b wr_count=%0d, required 1 0 0 0 0",
                     timeout, bus.write, bus.read, bus.cmd_ready, wr_count);
        end
        respond($urandom);
        checks++;
        if ({err_count, err_pulse} !== {16'(m_err), m_pulse}) begin
            failures++;
            $display("FAIL halt_response: err_count=%0d pulse=%b, required %0d %b", err_count, err_pulse, m_err, m_pulse);
        end
        do_reset();
        checks++;
        if ({timeout, bus.cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_clear: timeout=%b cmd_ready=%b, required 0 1", timeout, bus.cmd_ready);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_be = '0; bus.cmd_data = '0;
        bus.ready = 1'b0; bus.rd = '0; bus.rd_valid = 1'b0;
        model_clear();
        test_reset();
        test_write_read();
        test_masked();
        test_fifo_full();
        test_spurious();
        test_reset_midflight();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_req_gen.md
# cache_req_gen

Synthesizable CPU-side initiator for the L1 cache request port. It accepts a stream of read/write commands, drives them onto the cache `a/be/read/write/wd` interface, and holds each one until the cache asserts ready. It then checks every read response, in order, against an expected value it has queued. It replaces the behavioural task-driven stimulus in the cache benches, so that directed and random command streams run at full handshake rate, including on FPGA.

## Interface
Parameters:
- OUTSTANDING, 4: depth of the expected-read FIFO (max reads in flight), power of 2, ≥2
- MAX_WAIT, 64: cycles without progress before timeout, ≥2
- CNT_W, 16: width of status counters

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; all state cleared while low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 nop, 01 read, 10 write, 11 reserved (treated as nop)
- cmd_addr  in  32  byte address
- cmd_be  in  4  byte enables
- cmd_data  in  32  write data (write) / expected data (read)
- a  out  32  cache address
- be  out  4  cache byte enables
- read  out  1  cache read request
- write  out  1  cache write request
- wd  out  32  cache write data
- ready  in  1  cache ready; request accepted when (read|write) & ready
- rd  in  32  cache read data
- rd_valid  in  1  rd valid, responses in request order
- busy  out  1  request pending or FIFO non-empty
- rd_count, wr_count  out  CNT_W  accepted reads/writes, saturating
- err_count  out  CNT_W  mismatches + spurious responses, saturating
- err_pulse  out  1  one-cycle pulse per error
- last_err_addr  out  32  address of most recent mismatching read
- timeout  out  1  sticky watchdog flag

## Operation
- Reset values: all outputs 0. `cmd_ready` stays 0 while reset is low and goes to 1 in the first cycle after reset is released.
- FSM states: IDLE, REQ, HALT.
  - IDLE: cmd_ready=1. On a nop handshake, consume the command and stay in IDLE. On a read or write handshake, register a/be/wd/op and go to REQ.
  - REQ: drive read or write; cmd_ready=0.
    - A read drives `read` only while the FIFO is not full. While the FIFO is full, `read`=0 and the request waits.
    - On acceptance, return to IDLE. A read pushes {addr, be, data} into the FIFO. The matching rd/wr_count increments.
  - HALT: entered from any state on timeout. read=write=cmd_ready=0 and `timeout`=1 until reset. Responses are still checked in HALT.
- The FIFO pops on rd_valid. The compare is masked by the queued be: byte i is compared only if be[i]=1. A mismatch increments err_count, pulses err_pulse and loads last_err_addr.
- rd_valid with an empty FIFO is a spurious response: err_count+1 and err_pulse. last_err_addr does not change.
- A simultaneous push and pop leaves the FIFO count unchanged. Pointers wrap modulo OUTSTANDING.
- Watchdog:
  - Increments each cycle in which (REQ and not accepted) or (FIFO non-empty and no rd_valid).
  - Clears on any acceptance or rd_valid, and holds 0 otherwise.
  - Reaching MAX_WAIT goes to HALT.
- All counters saturate at all-ones.
- reset low mid-transaction drops any pending request and flushes the FIFO. Responses arriving after reset release are spurious.

## Timing
- A command handshake in cycle N puts read/write high from cycle N+1. There is a one-cycle bubble per command, so the peak rate is one request per 2 cycles.
- If ready is high in N+1, the request is accepted and read/write are 0 in N+2. cmd_ready is 1 in N+2.
- rd_valid in cycle M updates err_count, err_pulse and last_err_addr in cycle M+1. The FIFO pop is visible in M+1.
- All outputs are registered, with no combinational path from inputs to outputs. Exception: the full-gating of `read` is derived from registered state only.

## Structure
- Package `cache_tb_pkg` holds:
  - the op encoding enum (OP_NOP, OP_RD, OP_WR)
  - the FSM state enum
  - the expected-entry struct {addr[31:0], be[3:0], data[31:0]}
- Sub-module `exp_fifo`: a synchronous FIFO, parameterized on depth and the entry type, with push/pop/full/empty/count outputs. Simultaneous push and pop are legal.

## Test plan
- Reset, then write 0xDEADBEEF to 0x100 with be=F, ready=1. Requires write=1 at N+1 and wr_count=1. Then read 0x100 expecting 0xDEADBEEF with rd_valid 1 cycle later: err_count stays 0.
- Read 0x40 with be=0x3, expected 0x0000_1234, response rd=0xFFFF_1234. Requires err_count=0 (masked bytes ignored). Repeat with rd=0x0000_1235: err_count=1, last_err_addr=0x40, one err_pulse.
- Issue 6 reads with OUTSTANDING=4 and no responses. Requires exactly 4 accepted and `read`=0 on the 5th. Return one rd_valid: the 5th read issues 1 cycle later.
- Hold ready=0 for MAX_WAIT=64 cycles on a pending write. Requires timeout=1 at cycle 64, write=0 and cmd_ready=0 until reset.
- Assert rd_valid with no reads outstanding. Requires err_count=1, last_err_addr=0.
- Assert reset low with 2 reads in flight, then release. Requires all outputs 0 and busy=0. A later rd_valid counts as spurious.
